// File: rtl/signed_mac_if.sv
// Handshake bundle between the multiplier, the MAC accumulator and the result consumer.
// The master modport belongs to whoever feeds products and takes results; the slave modport belongs to the accumulator.
interface signed_mac_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 12
);
    logic [PROD_W-1:0] prod_i;
    logic              prod_valid;
    logic              prod_ready;
    logic              clear;
    logic [ACC_W-1:0]  acc_o;
    logic              acc_valid;
    logic              acc_ready;
    logic [7:0]        term_cnt;
    logic              overflow;

    modport master (
        output prod_i, prod_valid, clear, acc_ready,
        input  prod_ready, acc_o, acc_valid, term_cnt, overflow
    );

    modport slave (
        input  prod_i, prod_valid, clear, acc_ready,
        output prod_ready, acc_o, acc_valid, term_cnt, overflow
    );
endinterface

// File: rtl/signed_mac_accumulator.sv
// Sums N_TERMS signed products into a signed ACC_W result delivered over a valid/ready handshake.
// Optional macro SIGNED_MAC_SATURATE_EN: clamp on overflow instead of wrapping.
module signed_mac_accumulator #(
    parameter int PROD_W  = 8,
    parameter int ACC_W   = 12,
    parameter int N_TERMS = 4
) (
    input  logic        clk,
    input  logic        rst,
    signed_mac_if.slave bus
);
    typedef enum logic {ST_ACC, ST_DONE} state_t;

    localparam logic [7:0] LAST_CNT = 8'(N_TERMS - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                  state_q, state_d;
    logic                    live_q;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic signed [ACC_W-1:0] addend, sum;
    logic                    add_ovf, xfer;

    assign addend  = ACC_W'($signed(bus.prod_i));
    assign sum     = acc_q + addend;
    assign add_ovf = (acc_q[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    assign xfer    = bus.prod_valid && bus.prod_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (bus.clear) begin
            state_d = ST_ACC;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (xfer) begin
`ifdef SIGNED_MAC_SATURATE_EN
                        // Clamp direction follows the shared sign of the two addends.
                        if (add_ovf)
                            acc_d = addend[ACC_W-1] ? ACC_MIN : ACC_MAX;
                        else
                            acc_d = sum;
`else
                        acc_d = sum;
`endif
                        cnt_d = cnt_q + 8'd1;
                        ovf_d = ovf_q | add_ovf;
                        if (cnt_q == LAST_CNT)
                            state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.acc_ready) begin
                        state_d = ST_ACC;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = ST_ACC;
            endcase
        end
    end

    // live_q keeps prod_ready low until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACC;
            live_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.prod_ready = live_q && (state_q == ST_ACC);
    assign bus.acc_valid  = (state_q == ST_DONE);
    assign bus.acc_o      = acc_q;
    assign bus.term_cnt   = cnt_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_signed_mac_accumulator.sv
// Directed bench: default instance plus two narrow instances (ACC_W=8, N_TERMS=2 and 3) for overflow cases.
module tb_signed_mac_accumulator;
    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    signed_mac_if #(.PROD_W(8), .ACC_W(12)) ifa ();
    signed_mac_if #(.PROD_W(8), .ACC_W(8))  ifb ();
    signed_mac_if #(.PROD_W(8), .ACC_W(8))  ifc ();

    signed_mac_accumulator #(.PROD_W(8), .ACC_W(12), .N_TERMS(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    signed_mac_accumulator #(.PROD_W(8), .ACC_W(8),  .N_TERMS(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
    signed_mac_accumulator #(.PROD_W(8), .ACC_W(8),  .N_TERMS(3)) dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        $display("check %-22s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] t1_vec [4];
        logic [7:0] exp_b;
        logic [7:0] exp_c;
        n_total = 0;
        n_pass  = 0;
        t1_vec[0] = 8'h03; t1_vec[1] = 8'hFE; t1_vec[2] = 8'h40; t1_vec[3] = 8'hC8;
`ifdef SIGNED_MAC_SATURATE_EN
        exp_b = 8'h7F;
        exp_c = 8'h80;
`else
        exp_b = 8'h80;
        exp_c = 8'h58;
`endif
        ifa.prod_i = '0; ifa.prod_valid = 0; ifa.clear = 0; ifa.acc_ready = 0;
        ifb.prod_i = '0; ifb.prod_valid = 0; ifb.clear = 0; ifb.acc_ready = 0;
        ifc.prod_i = '0; ifc.prod_valid = 0; ifc.clear = 0; ifc.acc_ready = 0;

        // Reset state
        rst = 1'b1;
        #2;
        check("rst_prod_ready", 32'(ifa.prod_ready), 32'd0);
        check("rst_acc_valid",  32'(ifa.acc_valid),  32'd0);
        check("rst_acc_o",      32'(ifa.acc_o),      32'd0);
        check("rst_term_cnt",   32'(ifa.term_cnt),   32'd0);
        check("rst_overflow",   32'(ifa.overflow),   32'd0);
        step();
        check("rst_hold_ready", 32'(ifa.prod_ready), 32'd0);
        #2 rst = 1'b0;
        step();
        check("post_rst_ready", 32'(ifa.prod_ready), 32'd1);

        // T1: four back-to-back products
        ifa.prod_valid = 1;
        for (int i = 0; i < 4; i++) begin
            ifa.prod_i = t1_vec[i];
            step();
        end
        check("t1_acc_valid",  32'(ifa.acc_valid),  32'd1);
        check("t1_acc_o",      32'(ifa.acc_o),      32'h009);
        check("t1_term_cnt",   32'(ifa.term_cnt),   32'd4);
        check("t1_overflow",   32'(ifa.overflow),   32'd0);
        check("t1_prod_ready", 32'(ifa.prod_ready), 32'd0);

        // T2: backpressure with prod_valid held high
        ifa.prod_i = 8'h11;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_hold_acc_o",    32'(ifa.acc_o),      32'h009);
            check("t2_hold_ready",    32'(ifa.prod_ready), 32'd0);
            check("t2_hold_term_cnt", 32'(ifa.term_cnt),   32'd4);
        end
        ifa.acc_ready = 1;
        step();
        ifa.acc_ready = 0;
        ifa.prod_valid = 0;
        check("t2_rel_ready",    32'(ifa.prod_ready), 32'd1);
        check("t2_rel_acc_o",    32'(ifa.acc_o),      32'd0);
        check("t2_rel_valid",    32'(ifa.acc_valid),  32'd0);
        check("t2_rel_term_cnt", 32'(ifa.term_cnt),   32'd0);

        // T3: ACC_W=8, N_TERMS=2, 0x40 + 0x40
        ifb.prod_valid = 1;
        ifb.prod_i = 8'h40;
        step();
        check("t3_mid_overflow", 32'(ifb.overflow), 32'd0);
        step();
        ifb.prod_valid = 0;
        check("t3_acc_valid", 32'(ifb.acc_valid), 32'd1);
        check("t3_acc_o",     32'(ifb.acc_o),     32'(exp_b));
        check("t3_overflow",  32'(ifb.overflow),  32'd1);
        ifb.acc_ready = 1;
        step();
        ifb.acc_ready = 0;
        check("t3_ovf_cleared", 32'(ifb.overflow), 32'd0);

        // T4: ACC_W=8, N_TERMS=3, 0xC8 x3
        ifc.prod_valid = 1;
        ifc.prod_i = 8'hC8;
        step();
        step();
        check("t4_mid_acc_o",    32'(ifc.acc_o),    32'h90);
        check("t4_mid_overflow", 32'(ifc.overflow), 32'd0);
        step();
        ifc.prod_valid = 0;
        check("t4_acc_valid", 32'(ifc.acc_valid), 32'd1);
        check("t4_acc_o",     32'(ifc.acc_o),     32'(exp_c));
        check("t4_overflow",  32'(ifc.overflow),  32'd1);

        // T5: clear beats a simultaneous transfer
        ifa.prod_valid = 1;
        ifa.prod_i = 8'h05;
        step();
        step();
        check("t5_pre_term_cnt", 32'(ifa.term_cnt), 32'd2);
        check("t5_pre_acc_o",    32'(ifa.acc_o),    32'h00A);
        ifa.clear = 1;
        ifa.prod_i = 8'h07;
        step();
        ifa.clear = 0;
        check("t5_clr_acc_o",    32'(ifa.acc_o),    32'd0);
        check("t5_clr_term_cnt", 32'(ifa.term_cnt), 32'd0);
        ifa.prod_i = 8'h01;
        for (int i = 0; i < 4; i++) step();
        ifa.prod_valid = 0;
        check("t5_acc_valid", 32'(ifa.acc_valid), 32'd1);
        check("t5_acc_o",     32'(ifa.acc_o),     32'h004);
        // clear while a result is pending discards it
        ifa.clear = 1;
        step();
        ifa.clear = 0;
        check("t5_done_clr_valid", 32'(ifa.acc_valid), 32'd0);
        check("t5_done_clr_acc_o", 32'(ifa.acc_o),     32'd0);
        check("t5_done_clr_ready", 32'(ifa.prod_ready), 32'd1);

        // T6: asynchronous reset between edges mid-burst
        ifa.prod_valid = 1;
        ifa.prod_i = 8'h02;
        step();
        step();
        ifa.prod_valid = 0;
        check("t6_pre_term_cnt", 32'(ifa.term_cnt), 32'd2);
        #2 rst = 1'b1;
        #1;
        check("t6_async_term_cnt", 32'(ifa.term_cnt),   32'd0);
        check("t6_async_acc_o",    32'(ifa.acc_o),      32'd0);
        check("t6_async_valid",    32'(ifa.acc_valid),  32'd0);
        check("t6_async_ready",    32'(ifa.prod_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("t6_release_ready", 32'(ifa.prod_ready), 32'd0);
        step();
        check("t6_first_edge_ready", 32'(ifa.prod_ready), 32'd1);
        ifa.prod_valid = 1;
        for (int i = 0; i < 4; i++) step();
        ifa.prod_valid = 0;
        check("t6_acc_valid", 32'(ifa.acc_valid), 32'd1);
        check("t6_acc_o",     32'(ifa.acc_o),     32'h008);
        check("t6_term_cnt",  32'(ifa.term_cnt),  32'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
